// File: rtl/conv_acc_pkg.sv
// rtl/conv_acc_pkg.sv - shared widths and helpers for the conv write-side packer
//
// Purpose: default slice/word widths, keep-width constant and the slice
// counter width helper used by packer and its holding register.
package conv_acc_pkg;

  localparam int DEF_IN_WIDTH   = 64;
  localparam int DEF_OUT_WIDTH  = 512;
  localparam int DEF_KEEP_WIDTH = DEF_OUT_WIDTH / 8;

  // Counter must hold 0..max_cnt-1; never narrower than one bit.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt <= 2) ? 1 : $clog2(max_cnt);
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// rtl/packer_out_reg.sv - single-entry valid/ready holding register for data/keep/last
//
// Purpose: holds one stream word and presents it until the consumer takes it.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   load                        capture load_data/keep/last (caller checks ready)
//   load_data/keep/last         word to capture
//   ready                       register is empty or drains this cycle
//   out_data/keep/last/valid    held word toward the consumer
//   out_ready                   consumer accepts the word
module packer_out_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic              ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  assign ready = !out_valid || out_ready;

  // Fields change only on load, so a stalled word stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/packer.sv
// rtl/packer.sv - gathers datapath slices into wide stream words with keep/last
//
// Purpose: slice k of a word lands in bits [k*IN_WIDTH +: IN_WIDTH]; a word is
// emitted when full or when in_last closes the frame (zero padded, keep mask).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready  slice stream from the datapath
//   out_data/out_keep/out_last         packed word and byte enables
//   out_valid/out_ready                word handshake toward memory
//   busy                               partial word held or word pending
module packer
  import conv_acc_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int MAX_CNT   = OUT_WIDTH / IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [OUT_WIDTH/8-1:0] out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW  = cnt_width(MAX_CNT);
  localparam int KW  = OUT_WIDTH / 8;
  localparam int SKW = IN_WIDTH / 8;

  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] asm_data;
  logic [KW-1:0]        asm_keep;
  logic                 ready_en;   // holds in_ready low for the first cycle out of reset
  logic                 oreg_ready;

  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] word_data;
  logic [KW-1:0]        word_keep;

  // Conservative backpressure: stall on any pending undrained word, even when
  // the next slice would not complete one.
  assign in_ready = ready_en && oreg_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((cnt == CW'(MAX_CNT - 1)) || in_last);
  assign busy     = (cnt != '0) || out_valid;

  // Assembly contents merged with the slice being accepted now. Slices not yet
  // written are already zero with keep clear, which gives the flush padding.
  always_comb begin
    word_data = asm_data;
    word_keep = asm_keep;
    word_data[cnt*IN_WIDTH +: IN_WIDTH] = in_data;
    word_keep[cnt*SKW +: SKW]           = {SKW{1'b1}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      cnt      <= '0;
      asm_data <= '0;
      asm_keep <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (complete) begin
          cnt      <= '0;
          asm_data <= '0;
          asm_keep <= '0;
        end else begin
          cnt      <= cnt + CW'(1);
          asm_data <= word_data;
          asm_keep <= word_keep;
        end
      end
    end
  end

  packer_out_reg #(
    .DATA_W (OUT_WIDTH),
    .KEEP_W (KW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data (word_data),
    .load_keep (word_keep),
    .load_last (in_last),
    .ready     (oreg_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_packer.sv
// tb/tb_packer.sv - self-checking bench for packer
module tb_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] out_data;
  logic [63:0]  out_keep;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] SA = 64'h1111_1111_1111_1111;
  localparam logic [63:0] SB = 64'h2222_2222_2222_2222;
  localparam logic [63:0] SC = 64'h3333_3333_3333_3333;

  typedef struct {
    logic         v;
    logic         l;
    logic [63:0]  d;
    logic         r;
    logic         e_ir;
    logic         e_ov;
    logic         e_ol;
    logic         e_busy;
    logic [63:0]  e_keep;
    logic [511:0] e_data;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic logic [511:0] wmk(input logic [63:0] base, input int n);
    logic [511:0] w = '0;
    for (int k = 0; k < n; k++) w[k*64 +: 64] = base + 64'(k);
    return w;
  endfunction

  function automatic logic [63:0] kmk(input int n);
    logic [63:0] m = '0;
    for (int k = 0; k < n*8; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic l, input logic [63:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic add(input logic v, input logic l, input logic [63:0] d, input logic r,
                     input logic e_ir, input logic e_ov, input logic e_ol, input logic e_busy,
                     input logic [63:0] e_keep, input logic [511:0] e_data);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.r = r;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_ol = e_ol; t.e_busy = e_busy;
    t.e_keep = e_keep; t.e_data = e_data;
    vq.push_back(t);
  endtask

  task automatic chk_word(input string name, input logic [511:0] d, input logic [63:0] k, input logic l);
    chk({name, ".out_valid"}, 512'(out_valid), 512'(1'b1));
    chk({name, ".out_data"},  out_data, d);
    chk({name, ".out_keep"},  512'(out_keep), 512'(k));
    chk({name, ".out_last"},  512'(out_last), 512'(l));
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".in_ready"},  512'(in_ready), 512'(1'b0));
    chk({name, ".out_valid"}, 512'(out_valid), 512'(1'b0));
    chk({name, ".out_data"},  out_data, 512'(0));
    chk({name, ".out_keep"},  512'(out_keep), 512'(0));
    chk({name, ".out_last"},  512'(out_last), 512'(1'b0));
    chk({name, ".busy"},      512'(busy), 512'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state and the one-cycle in_ready delay after release.
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_release.in_ready", 512'(in_ready), 512'(1'b0));

    // Full word, partial flush, then single-slice frame at cnt=0.
    for (int i = 0; i < 8; i++)
      add(1, 0, 64'(i), 1, 1, 0, 0, (i > 0), '0, '0);
    add(0, 0, 0, 1, 1, 1, 0, 1, kmk(8), wmk(0, 8));
    add(0, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 0, SA, 1, 1, 0, 0, 0, '0, '0);
    add(1, 0, SB, 1, 1, 0, 0, 1, '0, '0);
    add(1, 1, SC, 1, 1, 0, 0, 1, '0, '0);
    add(0, 0, 0, 1, 1, 1, 1, 1, 64'h0000_0000_00FF_FFFF, {320'b0, SC, SB, SA});
    add(1, 1, 64'hDEAD, 1, 1, 0, 0, 0, '0, '0);
    add(0, 0, 0, 1, 1, 1, 1, 1, 64'hFF, {448'b0, 64'hDEAD});
    add(0, 0, 0, 1, 1, 0, 0, 0, '0, '0);

    foreach (vq[i]) begin
      step(vq[i].v, vq[i].l, vq[i].d, vq[i].r);
      chk($sformatf("vec%0d.in_ready", i),  512'(in_ready),  512'(vq[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 512'(out_valid), 512'(vq[i].e_ov));
      chk($sformatf("vec%0d.busy", i),      512'(busy),      512'(vq[i].e_busy));
      if (vq[i].e_ov) begin
        chk($sformatf("vec%0d.out_data", i), out_data, vq[i].e_data);
        chk($sformatf("vec%0d.out_keep", i), 512'(out_keep), 512'(vq[i].e_keep));
        chk($sformatf("vec%0d.out_last", i), 512'(out_last), 512'(vq[i].e_ol));
      end
    end

    // Streaming: 24 slices back to back, three words, in_ready never drops.
    for (int j = 0; j < 26; j++) begin
      step(j < 24, 1'b0, 64'h200 + 64'(j), 1'b1);
      chk($sformatf("stream%0d.in_ready", j), 512'(in_ready), 512'(1'b1));
      chk($sformatf("stream%0d.out_valid", j), 512'(out_valid),
          512'(j == 8 || j == 16 || j == 24));
      if (j == 8 || j == 16 || j == 24)
        chk($sformatf("stream%0d.out_data", j), out_data, wmk(64'h200 + 64'((j/8 - 1) * 8), 8));
    end

    // Backpressure: word 1 pending with out_ready low stalls input and holds.
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 64'h100 + 64'(j), 0);
      chk($sformatf("bp_fill%0d.in_ready", j), 512'(in_ready), 512'(1'b1));
    end
    for (int j = 0; j < 3; j++) begin
      step(1, 0, 64'h108, 0);
      chk($sformatf("bp_stall%0d.in_ready", j), 512'(in_ready), 512'(1'b0));
      chk_word($sformatf("bp_stall%0d", j), wmk(64'h100, 8), kmk(8), 1'b0);
    end
    // Release: word drains and the stalled slice is taken on the same edge.
    step(1, 0, 64'h108, 1);
    chk("bp_release.in_ready", 512'(in_ready), 512'(1'b1));
    chk_word("bp_release", wmk(64'h100, 8), kmk(8), 1'b0);
    for (int j = 1; j < 8; j++) begin
      step(1, 0, 64'h108 + 64'(j), 0);
      chk($sformatf("bp_w2_%0d.in_ready", j), 512'(in_ready), 512'(1'b1));
      chk($sformatf("bp_w2_%0d.out_valid", j), 512'(out_valid), 512'(1'b0));
    end
    for (int j = 0; j < 2; j++) begin
      step(1, 0, 64'h110, 0);
      chk($sformatf("bp_w2_stall%0d.in_ready", j), 512'(in_ready), 512'(1'b0));
      chk_word($sformatf("bp_w2_stall%0d", j), wmk(64'h108, 8), kmk(8), 1'b0);
      chk($sformatf("bp_w2_stall%0d.busy", j), 512'(busy), 512'(1'b1));
    end

    // Reset with an output word pending: everything clears at once.
    rst_n = 1'b0;
    #1 chk_zero("rst_pending");
    step(0, 0, 0, 1);
    rst_n = 1'b1;

    // Reset with a partial word (cnt=5) held.
    for (int j = 0; j < 5; j++) step(1, 0, 64'h300 + 64'(j), 1);
    step(0, 0, 0, 1);
    chk("rst_partial.busy_before", 512'(busy), 512'(1'b1));
    rst_n = 1'b0;
    #1 chk_zero("rst_partial");
    step(0, 0, 0, 1);
    rst_n = 1'b1;
    step(0, 0, 0, 1);

    // Clean word after reset: no stale slices from the discarded partial.
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 64'h400 + 64'(j), 1);
      chk($sformatf("clean%0d.in_ready", j), 512'(in_ready), 512'(1'b1));
    end
    step(0, 0, 0, 1);
    chk_word("clean", wmk(64'h400, 8), kmk(8), 1'b0);
    step(0, 0, 0, 1);
    chk("clean_idle.busy", 512'(busy), 512'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
